// File: rtl/seq_shift_unit_if.sv
// Request/result handshake bundle for the iterative shifter.
// The requester drives operands and accepts results; the shifter serves them.
interface seq_shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             busy;

  modport master (
    output in_valid,
    output in_data,
    output in_amt,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_carry,
    input  out_zero,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amt,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_carry,
    output out_zero,
    output busy
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Iterative shifter: one bit position per clock, SLL/SRL/SRA/ROL.
// Result and carry are held in DONE until the consumer takes them.
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic clk,
  input logic rst_n,
  seq_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] cnt_nxt;
  logic [1:0]       mode;
  logic [1:0]       mode_nxt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             res_carry;
  logic             res_carry_nxt;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  always_comb begin
    step_data  = work;
    step_carry = 1'b0;
    unique case (1'b1)
      (mode == 2'b00): begin
        step_data  = {work[WIDTH-2:0], 1'b0};
        step_carry = work[WIDTH-1];
      end
      (mode == 2'b01): begin
        step_data  = {1'b0, work[WIDTH-1:1]};
        step_carry = work[0];
      end
      (mode == 2'b10): begin
        step_data  = {work[WIDTH-1], work[WIDTH-1:1]};
        step_carry = work[0];
      end
      (mode == 2'b11): begin
        step_data  = {work[WIDTH-2:0], work[WIDTH-1]};
        step_carry = work[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Result registers update only on entry to DONE so they hold through IDLE.
  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    cnt_nxt       = cnt;
    mode_nxt      = mode;
    res_nxt       = res;
    res_carry_nxt = res_carry;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          work_nxt = bus.in_data;
          cnt_nxt  = bus.in_amt;
          mode_nxt = bus.in_mode;
          if (bus.in_amt == '0) begin
            state_nxt     = DONE;
            res_nxt       = bus.in_data;
            res_carry_nxt = 1'b0;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_nxt = step_data;
        cnt_nxt  = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_nxt     = DONE;
          res_nxt       = step_data;
          res_carry_nxt = step_carry;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      mode      <= 2'b00;
      res       <= '0;
      res_carry <= 1'b0;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      cnt       <= cnt_nxt;
      mode      <= mode_nxt;
      res       <= res_nxt;
      res_carry <= res_carry_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = res;
  assign bus.out_carry = res_carry;
  assign bus.out_zero  = (res == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed vector bench for seq_shift_unit.
// Table of single ops plus backpressure and mid-shift reset sequences.
module tb_seq_shift_unit;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  seq_shift_unit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  seq_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic [1:0] mode;
    logic [7:0] exp_data;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the release edge.
  task automatic run_op(input vec_t v, input string name);
    int lat;
    bus.in_data  = v.data;
    bus.in_amt   = v.amt;
    bus.in_mode  = v.mode;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, (v.amt == 0) ? 1 : v.amt + 1);
    check({name, " data"}, bus.out_data, v.exp_data);
    check({name, " carry"}, bus.out_carry, v.exp_carry);
    check({name, " zero"}, bus.out_zero, (v.exp_data == 8'h00));
    check({name, " in_ready low"}, bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, " in_ready back"}, bus.in_ready, 1'b1);
  endtask

  task automatic check_idle_reset(input string name);
    check({name, " in_ready"}, bus.in_ready, 1'b1);
    check({name, " out_valid"}, bus.out_valid, 1'b0);
    check({name, " busy"}, bus.busy, 1'b0);
    check({name, " out_data"}, bus.out_data, 8'h00);
    check({name, " out_carry"}, bus.out_carry, 1'b0);
    check({name, " out_zero"}, bus.out_zero, 1'b1);
  endtask

  initial begin
    vec_t v;
    int   seen;
    n_run  = 0;
    n_fail = 0;

    vecs[0] = '{8'hA5, 3'd3, 2'b00, 8'h28, 1'b1};
    vecs[1] = '{8'hA5, 3'd2, 2'b01, 8'h29, 1'b0};
    vecs[2] = '{8'hA5, 3'd2, 2'b10, 8'hE9, 1'b0};
    vecs[3] = '{8'hA5, 3'd3, 2'b11, 8'h2D, 1'b1};
    vecs[4] = '{8'h80, 3'd7, 2'b11, 8'h40, 1'b0};
    vecs[5] = '{8'h5A, 3'd0, 2'b10, 8'h5A, 1'b0};
    vecs[6] = '{8'h01, 3'd1, 2'b01, 8'h00, 1'b1};
    vecs[7] = '{8'hFF, 3'd7, 2'b10, 8'hFF, 1'b1};
    vecs[8] = '{8'hFF, 3'd7, 2'b01, 8'h01, 1'b1};
    vecs[9] = '{8'h81, 3'd1, 2'b00, 8'h02, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold 0x80 for 5 cycles while a second request waits.
    v = '{8'hFF, 3'd7, 2'b00, 8'h80, 1'b1};
    bus.in_data  = v.data;
    bus.in_amt   = v.amt;
    bus.in_mode  = v.mode;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_data = 8'h01;
    bus.in_amt  = 3'd1;
    bus.in_mode = 2'b00;
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", bus.out_valid, 1'b1);
      check("bp in_ready", bus.in_ready, 1'b0);
      check("bp data", bus.out_data, 8'h80);
      check("bp carry", bus.out_carry, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp release in_ready", bus.in_ready, 1'b1);
    check("bp release busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp second accepted", bus.busy, 1'b1);
    @(posedge clk);
    #1;
    check("bp second valid", bus.out_valid, 1'b1);
    check("bp second data", bus.out_data, 8'h02);
    check("bp second carry", bus.out_carry, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of a 6-step shift discards the op.
    bus.in_data  = 8'h3C;
    bus.in_amt   = 3'd6;
    bus.in_mode  = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort busy before reset", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_reset("abort");
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("abort no result", seen, 0);
    run_op(vecs[0], "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
